// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment display scan blocks.
package seg_pkg;

   localparam int SEG_NDIG = 4;
   localparam int IDXW     = $clog2(SEG_NDIG);
   localparam int SEL_W    = 32;

   localparam logic [SEL_W-1:0] AN_OFF = '1;

   typedef enum logic {
      GUARD = 1'b0,
      DRIVE = 1'b1
   } slot_state_t;

   // One-cold anode select; callers truncate to their digit count.
   function automatic logic [SEL_W-1:0] digit_sel(input logic [4:0] i_idx);
      return ~(SEL_W'(1) << i_idx);
   endfunction

endpackage

// File: rtl/seg_prescale.sv
// Free-running DIV-cycle counter with a single-cycle wrap strike on the last count.
module seg_prescale
   import seg_pkg::*;
#(
   parameter  int DIV = 50000,
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   output logic [CW-1:0] o_cnt,
   output logic          o_wrap
);

   logic [CW-1:0] r_cnt;

   assign o_wrap = (r_cnt == CW'(DIV - 1));
   assign o_cnt  = r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (o_wrap) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed NDIG-digit common-anode scanner: double-buffered hex value,
// per-slot guard blanking and optional leading-zero suppression.
module seg7_scan
   import seg_pkg::*;
#(
   parameter int NDIG  = SEG_NDIG,
   parameter int DIV   = 50000,
   parameter int BLANK = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic [4*NDIG-1:0]       din,
   input  logic                    lz_en,
   output logic [3:0]              x,
   output logic [NDIG-1:0]         an,
   output logic [$clog2(NDIG)-1:0] idx,
   output logic                    frame
);

   localparam int IW = $clog2(NDIG);
   localparam int CW = $clog2(DIV);

   logic [CW-1:0]     w_cnt;
   logic              w_wrap;
   logic              w_frame_wrap;

   slot_state_t       r_state;
   slot_state_t       w_state_nxt;

   logic [IW-1:0]     r_idx;
   logic [IW-1:0]     w_idx_nxt;
   logic [4*NDIG-1:0] r_pending;
   logic [4*NDIG-1:0] r_active;
   logic [4*NDIG-1:0] w_active_nxt;
   logic [NDIG-1:0]   w_blank;
   logic              w_zrun;
   logic [NDIG-1:0]   w_sel;
   logic [NDIG-1:0]   r_an;
   logic [NDIG-1:0]   w_an_nxt;
   logic [3:0]        r_x;
   logic [3:0]        w_x_nxt;
   logic              r_frame;

   seg_prescale #(
      .DIV (DIV)
   ) u_prescale (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .o_cnt   (w_cnt),
      .o_wrap  (w_wrap)
   );

   assign w_frame_wrap = w_wrap && (r_idx == IW'(NDIG - 1));

   // Display data only swaps at the frame boundary so a frame never mixes old and new.
   assign w_active_nxt = w_frame_wrap ? (load ? din : r_pending) : r_active;

   always_comb begin
      w_idx_nxt = r_idx;
      if (w_wrap) begin
         w_idx_nxt = (r_idx == IW'(NDIG - 1)) ? '0 : r_idx + IW'(1);
      end
   end

   // A digit above 0 is blank when it and everything above it are zero.
   always_comb begin
      w_blank = '0;
      w_zrun  = 1'b1;
      for (int i = NDIG - 1; i >= 1; i--) begin
         w_zrun     = w_zrun && (w_active_nxt[4*i +: 4] == 4'h0);
         w_blank[i] = w_zrun;
      end
   end

   always_comb begin
      w_x_nxt = 4'h0;
      for (int i = 0; i < NDIG; i++) begin
         if (w_idx_nxt == IW'(i)) begin
            w_x_nxt = w_active_nxt[4*i +: 4];
         end
      end
   end

   assign w_sel = NDIG'(digit_sel(5'(w_idx_nxt)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= GUARD;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Outputs are computed from next-cycle state so they register in step with it.
   always_comb begin
      w_state_nxt = r_state;
      w_an_nxt    = NDIG'(AN_OFF);
      case (r_state)
         GUARD:   if (w_cnt == CW'(BLANK - 1)) w_state_nxt = DRIVE;
         DRIVE:   if (w_wrap)                  w_state_nxt = GUARD;
         default: w_state_nxt = GUARD;
      endcase
      if ((w_state_nxt == DRIVE) && !(lz_en && w_blank[w_idx_nxt])) begin
         w_an_nxt = w_sel;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx     <= '0;
         r_pending <= '0;
         r_active  <= '0;
         r_an      <= NDIG'(AN_OFF);
         r_x       <= 4'h0;
         r_frame   <= 1'b0;
      end else begin
         r_idx    <= w_idx_nxt;
         r_active <= w_active_nxt;
         r_an     <= w_an_nxt;
         r_x      <= w_x_nxt;
         r_frame  <= w_frame_wrap;
         if (load) begin
            r_pending <= din;
         end
      end
   end

   assign x     = r_x;
   assign an    = r_an;
   assign idx   = r_idx;
   assign frame = r_frame;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan with NDIG=4, DIV=4, BLANK=1.
module tb_seg7_scan;

   localparam int NDIG  = 4;
   localparam int DIV   = 4;
   localparam int BLANK = 1;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        load  = 1'b0;
   logic        lz_en = 1'b0;
   logic [15:0] din   = 16'h0;
   logic [3:0]  x;
   logic [3:0]  an;
   logic [1:0]  idx;
   logic        frame;

   int errors = 0;
   int checks = 0;

   int          m_cnt;
   int          m_idx;
   logic [15:0] m_pend;
   logic [15:0] m_act;

   typedef struct packed {
      logic [3:0] an;
      logic [3:0] x;
      logic [1:0] idx;
      logic       frame;
   } exp_t;

   exp_t q[$];
   exp_t e;

   always #5 clk = ~clk;

   seg7_scan #(
      .NDIG  (NDIG),
      .DIV   (DIV),
      .BLANK (BLANK)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .din   (din),
      .lz_en (lz_en),
      .x     (x),
      .an    (an),
      .idx   (idx),
      .frame (frame)
   );

   task automatic model_reset();
      m_cnt  = 0;
      m_idx  = 0;
      m_pend = 16'h0;
      m_act  = 16'h0;
      q.delete();
   endtask

   // Drive one clock's inputs, push the expected post-edge outputs, advance the clock.
   task automatic tick(input logic ld, input logic [15:0] d, input logic lz);
      exp_t       ex;
      logic [3:0] one;
      bit         lit;
      load  = ld;
      din   = d;
      lz_en = lz;
      if (m_cnt == DIV - 1 && m_idx == NDIG - 1) m_act = ld ? d : m_pend;
      if (ld) m_pend = d;
      if (m_cnt == DIV - 1) begin
         m_cnt = 0;
         m_idx = (m_idx + 1) % NDIG;
      end else begin
         m_cnt++;
      end
      lit = (m_cnt >= BLANK) && !(lz && m_idx > 0 && (m_act >> (4 * m_idx)) == 16'h0);
      one = 4'b0001 << m_idx;
      ex.an    = lit ? ~one : 4'hF;
      ex.x     = m_act[4*m_idx +: 4];
      ex.idx   = 2'(m_idx);
      ex.frame = (m_idx == 0 && m_cnt == 0);
      q.push_back(ex);
      @(posedge clk);
      #1;
      load = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++;
      if ({an, x, idx, frame} !== {4'hF, 4'h0, 2'd0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state: got an=%b x=%h idx=%0d frame=%b, want an=1111 x=0 idx=0 frame=0",
                  an, x, idx, frame);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_scan_order();
      int frames = 0;
      for (int i = 0; i < 32; i++) begin
         tick(1'b0, 16'h0, 1'b0);
         e = q.pop_front();
         checks++;
         if ({an, x, idx, frame} !== e) begin
            errors++;
            $display("FAIL scan_order: got %b want %b", {an, x, idx, frame}, e);
         end
         if (frame) frames++;
      end
      checks++;
      if (frames != 2) begin
         errors++;
         $display("FAIL frame_count: got %0d want 2", frames);
      end
   endtask

   task automatic test_display();
      logic [3:0] tab [4] = '{4'hF, 4'hA, 4'h2, 4'h1};
      bit seen = 0;
      tick(1'b1, 16'h12AF, 1'b0);
      e = q.pop_front();
      for (int i = 0; i < 40; i++) begin
         tick(1'b0, 16'h0, 1'b0);
         e = q.pop_front();
         checks++;
         if ({an, x, idx, frame} !== e) begin
            errors++;
            $display("FAIL display_seq: got %b want %b", {an, x, idx, frame}, e);
         end
         if (frame) seen = 1;
         if (seen && an !== 4'hF) begin
            checks++;
            if (x !== tab[idx]) begin
               errors++;
               $display("FAIL display_digit: idx=%0d got x=%h want %h", idx, x, tab[idx]);
            end
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL display_frame_timeout: got no frame want one");
      end
   endtask

   task automatic test_tear_free();
      bit got = 0;
      bit nf  = 0;
      tick(1'b1, 16'h2222, 1'b0);
      e = q.pop_front();
      for (int i = 0; i < 40 && !got; i++) begin
         tick(1'b0, 16'h0, 1'b0);
         e = q.pop_front();
         if (frame) got = 1;
      end
      while (m_idx != 2) begin
         tick(1'b0, 16'h0, 1'b0);
         e = q.pop_front();
      end
      tick(1'b1, 16'h1111, 1'b0);
      e = q.pop_front();
      for (int i = 0; i < 24; i++) begin
         tick(1'b0, 16'h0, 1'b0);
         e = q.pop_front();
         checks++;
         if ({an, x, idx, frame} !== e) begin
            errors++;
            $display("FAIL tear_seq: got %b want %b", {an, x, idx, frame}, e);
         end
         if (frame) nf = 1;
         if (an !== 4'hF) begin
            checks++;
            if (x !== (nf ? 4'h1 : 4'h2)) begin
               errors++;
               $display("FAIL tear_digit: idx=%0d got x=%h want %h", idx, x, nf ? 4'h1 : 4'h2);
            end
         end
      end
      checks++;
      if (!got || !nf) begin
         errors++;
         $display("FAIL tear_frame_timeout: got frames %0d/%0d want 1/1", got, nf);
      end
   endtask

   task automatic test_leading_zero();
      bit got;
      logic [15:0] vals [2] = '{16'h0070, 16'h0000};
      for (int v = 0; v < 2; v++) begin
         got = 0;
         tick(1'b1, vals[v], 1'b1);
         e = q.pop_front();
         for (int i = 0; i < 40 && !got; i++) begin
            tick(1'b0, 16'h0, 1'b1);
            e = q.pop_front();
            if (frame) got = 1;
         end
         checks++;
         if (!got) begin
            errors++;
            $display("FAIL lz_frame_timeout: got no frame want one");
         end
         for (int i = 0; i < 16; i++) begin
            tick(1'b0, 16'h0, 1'b1);
            e = q.pop_front();
            checks++;
            if ({an, x, idx, frame} !== e) begin
               errors++;
               $display("FAIL lz_seq: got %b want %b", {an, x, idx, frame}, e);
            end
            if (m_cnt >= BLANK) begin
               checks++;
               if (v == 0 && idx == 2'd1 && {an, x} !== {4'b1101, 4'h7}) begin
                  errors++;
                  $display("FAIL lz_digit1: got an=%b x=%h want an=1101 x=7", an, x);
               end else if (idx == 2'd0 && {an, x} !== {4'b1110, 4'h0}) begin
                  errors++;
                  $display("FAIL lz_digit0: got an=%b x=%h want an=1110 x=0", an, x);
               end else if (idx >= 2'd2 - v && idx != 2'd0 && an !== 4'hF) begin
                  errors++;
                  $display("FAIL lz_blank: idx=%0d got an=%b want 1111", idx, an);
               end
            end
         end
      end
   endtask

   task automatic test_wrap_load();
      for (int i = 0; i < 20 && !(m_idx == NDIG - 1 && m_cnt == DIV - 1); i++) begin
         tick(1'b0, 16'h0, 1'b0);
         e = q.pop_front();
      end
      tick(1'b1, 16'h5A5A, 1'b0);
      e = q.pop_front();
      checks++;
      if ({an, x, idx, frame} !== {4'hF, 4'hA, 2'd0, 1'b1}) begin
         errors++;
         $display("FAIL wrap_load_edge: got an=%b x=%h idx=%0d frame=%b want an=1111 x=a idx=0 frame=1",
                  an, x, idx, frame);
      end
      for (int i = 0; i < 19; i++) begin
         tick(1'b0, 16'h0, 1'b0);
         e = q.pop_front();
         checks++;
         if ({an, x, idx, frame} !== e) begin
            errors++;
            $display("FAIL wrap_load_seq: got %b want %b", {an, x, idx, frame}, e);
         end
         if (i < 3) begin
            checks++;
            if ({an, x} !== {4'b1110, 4'hA}) begin
               errors++;
               $display("FAIL wrap_load_slot0: got an=%b x=%h want an=1110 x=a", an, x);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 20 && !(m_idx == 2 && m_cnt == 2); i++) begin
         tick(1'b0, 16'h0, 1'b0);
         e = q.pop_front();
      end
      checks++;
      if ({an, x, idx} !== {4'b1011, 4'hA, 2'd2}) begin
         errors++;
         $display("FAIL async_pre: got an=%b x=%h idx=%0d want an=1011 x=a idx=2", an, x, idx);
      end
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({an, x, idx, frame} !== {4'hF, 4'h0, 2'd0, 1'b0}) begin
         errors++;
         $display("FAIL async_reset: got an=%b x=%h idx=%0d frame=%b want an=1111 x=0 idx=0 frame=0",
                  an, x, idx, frame);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      tick(1'b0, 16'h0, 1'b0);
      e = q.pop_front();
      checks++;
      if ({an, x, idx} !== {4'b1110, 4'h0, 2'd0}) begin
         errors++;
         $display("FAIL async_restart: got an=%b x=%h idx=%0d want an=1110 x=0 idx=0", an, x, idx);
      end
      for (int i = 0; i < 16; i++) begin
         tick(1'b0, 16'h0, 1'b0);
         e = q.pop_front();
         checks++;
         if ({an, x, idx, frame} !== e) begin
            errors++;
            $display("FAIL async_seq: got %b want %b", {an, x, idx, frame}, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_scan_order();
      test_display();
      test_tear_free();
      test_leading_zero();
      test_wrap_load();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
Time-multiplexed scanner for an NDIG-digit common-anode 7-segment display. Holds a double-buffered hex value and cycles one digit at a time. Each slot it drives that digit's 4-bit nibble to the downstream seg7 decoder and asserts the matching active-low anode. Inter-digit guard blanking and optional leading-zero suppression eliminate ghosting and stray zeros.

Parameters:
NDIG, 4, number of digits scanned (>=2)
DIV, 50000, clock cycles per digit slot (must be > BLANK)
BLANK, 16, guard cycles at the start of each slot with all anodes off (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
load  in  1  strobe; capture din into the pending buffer this edge
din  in  4*NDIG  hex digits; din[4i+3:4i] is digit i, digit 0 is least significant
lz_en  in  1  1 = suppress leading zeros
x  out  4  nibble of the current digit, feeds seg7 input x
an  out  NDIG  anode enables, active-low, at most one bit low
idx  out  clog2(NDIG)  index of the digit slot currently scanned
frame  out  1  one-cycle pulse on the first cycle of digit slot 0

Behaviour:
- Reset (async, rst_n=0): cnt=0, idx=0, state=GUARD, pending=0, active=0. Outputs: x=4'h0, an=all 1s, frame=0.
- Prescaler cnt counts 0..DIV-1 and wraps to 0. At cnt==DIV-1, idx advances: 0,1,...,NDIG-1, then back to 0.
- Per-slot FSM, all outputs registered:
  - GUARD: active while cnt < BLANK; an=all 1s.
  - DRIVE: active while BLANK <= cnt <= DIV-1; an[idx]=0, all other bits 1.
  - Transitions: GUARD->DRIVE when cnt==BLANK-1; DRIVE->GUARD when cnt==DIV-1.
  - Slot length is exactly DIV cycles; frame length is NDIG*DIV cycles.
- x = active[4*idx+3:4*idx]. It updates on the same edge idx changes, i.e. during GUARD, so x is stable before any anode goes low.
- frame pulses high for exactly the cycle in which idx==0 and cnt==0.
- Double buffer:
  - load=1 writes din into pending.
  - pending copies into active only on the edge where idx wraps NDIG-1 -> 0, so a displayed frame never mixes old and new data.
  - If load=1 on that same wrap edge, active takes din directly and pending also takes din.
  - load while not at the wrap edge: pending updated, display unchanged until the next wrap.
- Leading-zero suppression (lz_en=1):
  - Digit i>0 is blanked when it and every digit above it in active are 4'h0.
  - A blanked digit keeps an=all 1s for its whole slot; idx and x still advance normally.
  - Digit 0 is never blanked, so active=0 shows a single "0".
- lz_en is sampled each cycle; a change takes effect from the next DRIVE cycle.
- Reset asserted mid-slot clears everything immediately (async). First DRIVE after release starts at cnt==BLANK with idx=0.

Decomposition:
- Shared package seg_pkg:
  - Anode-off constant AN_OFF (all 1s).
  - Function digit_sel(idx) returning a one-cold NDIG-bit vector.
  - localparam IDXW = clog2(NDIG).
- One natural sub-module: seg_prescale.
  - Generic DIV-cycle counter producing cnt and a wrap strike.
  - Reused by future scan/debounce blocks.
- FSM, buffers and blanking live in seg7_scan.
- seg7 instances stay outside this block; the top level wires x -> seg7.x.

Test Plan:
(All scenarios use NDIG=4, DIV=4, BLANK=1.)
- Reset/scan order: release rst_n, no load -> every slot has 1 guard cycle with an=4'b1111, then 3 cycles at an=1110,1101,1011,0111 in turn, x=0 throughout. frame pulses every 16 cycles.
- Data display: load din=16'h12AF, wait for wrap -> x sequence per slot is F,A,2,1 with an low bits 0..3 respectively.
- Tear-free update: load 16'h1111 while idx=2 of a frame showing 16'h2222 -> idx 3 still shows 2. Next frame shows 1 on all digits.
- Leading-zero: lz_en=1, active=16'h0070 -> digits 3,2 keep an=1111 all slot. Digit 1 shows x=7, digit 0 shows x=0. With active=16'h0000 only digit 0 is lit.
- Load on wrap edge: assert load din=16'h5A5A exactly on the idx 3->0 edge -> slot 0 of the new frame shows x=A.
- Async reset mid-DRIVE: drop rst_n at cnt=2, idx=2 -> an=1111 and x=0 immediately without a clock edge. Scan restarts at idx=0 after release.
